// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, with optional
// repeats separated by idle gaps, and pulses done when the last repeat finishes.
module seq_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             cp,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       repeat_n,
    input  logic [3:0]       gap,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           cur;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [3:0]       rep_left;
    logic [3:0]       gap_q;
    logic [3:0]       gap_cnt;
    logic [LEN_W-1:0] len_eff;

    // Shift-based bit select keeps the index width independent of WIDTH.
    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign state   = cur;

    always_ff @(posedge cp or negedge reset) begin
        if (!reset) begin
            cur      <= IDLE;
            x        <= 1'b0;
            x_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pat_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            rep_left <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
        end else begin
            case (cur)
                IDLE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start && (len != '0)) begin
                        pat_q    <= pattern;
                        len_q    <= len_eff;
                        rep_left <= repeat_n;
                        gap_q    <= gap;
                        idx      <= len_eff - LEN_W'(1);
                        x        <= bit_at(pattern, len_eff - LEN_W'(1));
                        x_valid  <= 1'b1;
                        busy     <= 1'b1;
                        cur      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx != '0) begin
                        idx <= idx - LEN_W'(1);
                        x   <= bit_at(pat_q, idx - LEN_W'(1));
                    end else if (rep_left == 4'd0) begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        done    <= 1'b1;
                        cur     <= DONE;
                    end else if (gap_q == 4'd0) begin
                        rep_left <= rep_left - 4'd1;
                        idx      <= len_q - LEN_W'(1);
                        x        <= bit_at(pat_q, len_q - LEN_W'(1));
                    end else begin
                        rep_left <= rep_left - 4'd1;
                        gap_cnt  <= gap_q - 4'd1;
                        x        <= 1'b0;
                        x_valid  <= 1'b0;
                        cur      <= GAP;
                    end
                end
                // gap_cnt starts at gap-1, so the block idles for exactly gap cycles.
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        idx     <= len_q - LEN_W'(1);
                        x       <= bit_at(pat_q, len_q - LEN_W'(1));
                        x_valid <= 1'b1;
                        cur     <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                DONE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    cur     <= IDLE;
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a queue-based job model predicts every output cycle,
// directed jobs pin literal bit streams, then randomized traffic exercises the rest.
module tb_seq_pattern_tx;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic             cp = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [LEN_W-1:0] len = '0;
    logic [3:0]       repeat_n = '0;
    logic [3:0]       gap = '0;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;

    typedef struct packed {
        logic       xb;
        logic       vb;
        logic       bz;
        logic       dn;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;
    exp_t got;

    seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .cp(cp), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .repeat_n(repeat_n), .gap(gap), .x(x), .x_valid(x_valid), .busy(busy),
        .done(done), .state(state)
    );

    always #5 cp = ~cp;

    // Expands one accepted job into the full per-cycle output sequence.
    function automatic void buildJob(input logic [WIDTH-1:0] p, input int l, input int rep, input int g);
        int eff;
        eff = (l > WIDTH) ? WIDTH : l;
        for (int r = 0; r <= rep; r++) begin
            for (int b = eff - 1; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0, 2'd1});
            if (r < rep) for (int k = 0; k < g; k++) q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 2'd2});
        end
        q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 2'd3});
    endfunction

    always @(posedge cp or negedge reset) begin
        if (!reset) begin
            q.delete();
            cur = '0;
        end else begin
            if (q.size() == 0 && cur.st == 2'd0 && start && len != '0)
                buildJob(pattern, int'(len), int'(repeat_n), int'(gap));
            if (q.size() != 0) cur = q.pop_front();
            else cur = '0;
        end
    end

    always @(negedge cp) begin
        if (checkEn) begin
            got = {x, x_valid, busy, done, state};
            tests++;
            if (got !== cur) begin
                fails++;
                $display("[TB] FAIL cycle_check t=%0t got {x,v,busy,done,state}=%b expected=%b", $time, got, cur);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s got=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                                 input logic [3:0] rep, input logic [3:0] g);
        @(posedge cp);
        #1;
        pattern = p; len = l; repeat_n = rep; gap = g; start = 1'b1;
        @(posedge cp);
        #1;
        start = 1'b0;
    endtask

    // Records x/x_valid per cycle until done, bounded to 64 cycles.
    task automatic collect(output logic [31:0] xs, output logic [31:0] vs, output int dc);
        xs = '0; vs = '0; dc = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge cp);
            xs = {xs[30:0], x};
            vs = {vs[30:0], x_valid};
            if (done === 1'b1) begin
                dc = k;
                break;
            end
        end
    endtask

    logic [31:0] xs, vs;
    int dc;

    initial begin
        #1 reset = 1'b0;
        #20;
        checkEn = 1'b1;
        checkOutput("reset_state", 32'({x, x_valid, busy, done, state}), 32'h0);
        @(posedge cp); #3 reset = 1'b1;

        applyStimulus(16'h000D, 5'd4, 4'd0, 4'd0);
        collect(xs, vs, dc);
        checkOutput("single_x", xs, 32'h1A);
        checkOutput("single_valid", vs, 32'h1E);
        checkOutput("single_done_cycle", 32'(dc), 32'd5);

        applyStimulus(16'h0005, 5'd3, 4'd2, 4'd2);
        collect(xs, vs, dc);
        checkOutput("gap_x", xs, 32'h294A);
        checkOutput("gap_valid", vs, 32'h39CE);
        checkOutput("gap_done_cycle", 32'(dc), 32'd14);

        applyStimulus(16'h0002, 5'd2, 4'd3, 4'd0);
        collect(xs, vs, dc);
        checkOutput("b2b_x", xs, 32'h154);
        checkOutput("b2b_valid", vs, 32'h1FE);
        checkOutput("b2b_done_cycle", 32'(dc), 32'd9);

        applyStimulus(16'h8001, 5'd20, 4'd0, 4'd0);
        collect(xs, vs, dc);
        checkOutput("clamp_x", xs, 32'h10002);
        checkOutput("clamp_valid", vs, 32'h1FFFE);
        checkOutput("clamp_done_cycle", 32'(dc), 32'd17);

        applyStimulus(16'hFFFF, 5'd0, 4'd0, 4'd0);
        repeat (3) @(negedge cp);
        checkOutput("len0_idle", 32'({busy, done, state}), 32'h0);

        applyStimulus(16'h000D, 5'd4, 4'd0, 4'd0);
        fork
            collect(xs, vs, dc);
            begin
                @(posedge cp); #1 pattern = 16'hFFFF; start = 1'b1;
                @(posedge cp); #1 start = 1'b0;
                @(posedge cp);
                @(posedge cp); #1 start = 1'b1;
                @(posedge cp); #1 start = 1'b0;
            end
        join
        checkOutput("ignored_x", xs, 32'h1A);
        checkOutput("ignored_done_cycle", 32'(dc), 32'd5);
        repeat (2) @(negedge cp);
        checkOutput("ignored_after_idle", 32'({busy, done, state}), 32'h0);

        applyStimulus(16'h000D, 5'd4, 4'd0, 4'd0);
        @(posedge cp); #3 reset = 1'b0;
        #1 checkOutput("reset_midjob", 32'({x, x_valid, busy, done, state}), 32'h0);
        repeat (2) @(posedge cp);
        #3 reset = 1'b1;
        applyStimulus(16'h0009, 5'd4, 4'd0, 4'd0);
        collect(xs, vs, dc);
        checkOutput("post_reset_x", xs, 32'h12);
        checkOutput("post_reset_done_cycle", 32'(dc), 32'd5);

        for (int n = 0; n < 1500; n++) begin
            @(posedge cp);
            #1;
            pattern  = WIDTH'($urandom);
            len      = LEN_W'($urandom_range(0, 20));
            repeat_n = 4'($urandom_range(0, 3));
            gap      = 4'($urandom_range(0, 3));
            start    = ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
        repeat (100) @(posedge cp);
        @(negedge cp);
        checkOutput("final_idle", 32'({busy, state}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter that drives the single-bit `x` input of the team's Mealy sequence detector. A host loads a pattern word, its bit length, a repeat count and an inter-repeat gap, and pulses `start`. The block then shifts the pattern out MSB-first, one bit per `cp` cycle, with idle gaps between repeats and a one-cycle `done` pulse at the end. It replaces hand-timed `x` toggling in detector benches and serves as the stimulus end of the same one-bit serial interface in system builds.

## Interface
- `WIDTH`, default 16: maximum pattern length in bits.
- `LEN_W`, default 5: width of the `len` field, with 2^LEN_W > WIDTH.
- `cp` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a transmission; sampled only in IDLE.
- `pattern` input WIDTH: bits to send; active field is `pattern[len-1:0]`.
- `len` input LEN_W: number of bits per repeat.
  - 0 means the request is ignored.
  - Values above WIDTH are clamped to WIDTH.
- `repeat_n` input 4: extra repeats; total transmissions = `repeat_n`+1.
- `gap` input 4: idle cycles between repeats (0 means back-to-back).
- `x` output 1: serial data bit, registered.
- `x_valid` output 1: high while `x` carries a pattern bit.
- `busy` output 1: high from the cycle after an accepted start through the DONE cycle.
- `done` output 1: one-cycle pulse when the final repeat completes.
- `state` output 2: FSM state encoding.
  - IDLE = 0, SHIFT = 1, GAP = 2, DONE = 3.

## Operation
- Reset: asynchronously forces IDLE. All of `x`, `x_valid`, `busy`, `done` and `state` go to 0 immediately, and all internal counters clear.
- IDLE:
  - Outputs: `x`=0, `x_valid`=0, `busy`=0.
  - On an edge with `start`=1 and `len`≠0, the block latches:
    - `pattern`;
    - effective length L = min(`len`, WIDTH);
    - `repeat_n` into rep_left;
    - `gap`.
  - It then enters SHIFT with bit index = L-1, driving `x` = `pattern[L-1]` and `x_valid`=1.
  - If `start`=1 and `len`=0, the block stays in IDLE and raises no `done`.
- SHIFT:
  - Each edge decrements the bit index and drives `x` = latched `pattern[idx]`, so the order is MSB of the active field first, LSB last.
  - After the LSB cycle (index 0), the next state depends on rep_left and the latched gap:
    - rep_left=0 → DONE;
    - rep_left≠0 and gap=0 → restart SHIFT at index L-1 and decrement rep_left;
    - rep_left≠0 and gap≠0 → GAP with gap counter = gap-1, decrement rep_left.
- GAP:
  - Outputs: `x`=0, `x_valid`=0, `busy`=1.
  - The block counts down the gap counter.
  - On the edge where the counter reaches 0, it enters SHIFT at index L-1.
- DONE:
  - Outputs: `done`=1, `busy`=1, `x`=0, `x_valid`=0, for exactly one cycle.
  - The block then returns to IDLE unconditionally.
  - `start` during DONE is ignored.
- `start` and all input fields are ignored outside IDLE. Latched values are used for the entire job.
- Counters:
  - Bit index is LEN_W bits wide.
  - rep_left and the gap counter are 4 bits wide.
  - None of them ever wrap, because each decrements only while nonzero.

## Timing
- Latency: the first pattern bit appears on `x` in the cycle immediately after the accepting `cp` edge.
- `x` changes only on rising `cp` and is stable for a full cycle, so the detector samples it cleanly on the next edge.
- Job length in SHIFT/GAP cycles = (`repeat_n`+1)·L + `repeat_n`·`gap`. DONE follows in the very next cycle.
- A new `start` can be accepted on the first IDLE edge after DONE, giving a minimum of one idle cycle between jobs.
- Reset deassertion takes effect at the next rising `cp`. No outputs toggle before that edge.
- Reset asserted mid-SHIFT or mid-GAP aborts the job with no `done` pulse.

## Test plan
- Single shot: `pattern`=16'h000D, `len`=4, `repeat_n`=0, `gap`=0.
  - Expect `x` = 1,1,0,1 on the four cycles after start, with `x_valid`=1 throughout.
  - Expect `done`=1 in cycle 5, then IDLE with all outputs 0.
- Repeat with gap: `pattern`=3'b101, `len`=3, `repeat_n`=2, `gap`=2.
  - Expect `x`/`x_valid` = 1,0,1 / gap 0,0 (valid 0) / 1,0,1 / gap / 1,0,1.
  - Expect `done` at cycle 14.
- Back-to-back: `len`=2, `pattern`=2'b10, `repeat_n`=3, `gap`=0.
  - Expect `x` = 1,0,1,0,1,0,1,0 over 8 consecutive valid cycles, then `done`.
- Boundary lengths:
  - `len`=0 with `start`=1 → no state change, `busy`=0, no `done`.
  - `len`=20 with `pattern`=16'h8001 → clamped to 16 bits: 1, fourteen 0s, 1.
- Ignored start: pulse `start` with a different pattern during SHIFT and again in DONE. The original bit stream and `done` timing must be unchanged.
- Reset mid-job: assert `reset`=0 during the 2nd bit of a 4-bit job.
  - `x`, `x_valid`, `busy` and `state` go to 0 immediately, and no `done` is pulsed.
  - After release, a fresh start transmits correctly.
